// File: rtl/mdu_unit_pkg.sv
// ============================================================================
// Module : mdu_unit_pkg
// Brief  : Shared opcodes, widths and decode helper for the multiply/divide unit
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_unit_pkg;

    localparam int MDU_W = 32;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_calc.sv
// ============================================================================
// Module : mdu_calc
// Brief  : Combinational signed/unsigned multiply and divide producing {hi,lo}
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_calc
    import mdu_unit_pkg::*;
(
    input  logic [3:0]         op,
    input  logic [MDU_W-1:0]   rs_val,
    input  logic [MDU_W-1:0]   rt_val,
    output logic [2*MDU_W-1:0] result
);

    logic [2*MDU_W-1:0] sprod;
    logic [2*MDU_W-1:0] uprod;
    logic               den_zero;
    logic               sdiv_ovf;
    logic [MDU_W-1:0]   den;
    logic [MDU_W-1:0]   squot;
    logic [MDU_W-1:0]   srem;
    logic [MDU_W-1:0]   uquot;
    logic [MDU_W-1:0]   urem;

    assign sprod = $signed({{MDU_W{rs_val[MDU_W-1]}}, rs_val}) *
                   $signed({{MDU_W{rt_val[MDU_W-1]}}, rt_val});
    assign uprod = {{MDU_W{1'b0}}, rs_val} * {{MDU_W{1'b0}}, rt_val};

    // The divider never sees /0 or INT_MIN/-1; those results are forced below.
    assign den_zero = (rt_val == '0);
    assign sdiv_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    assign den      = (den_zero || sdiv_ovf) ? 32'd1 : rt_val;

    assign squot = $signed(rs_val) / $signed(den);
    assign srem  = $signed(rs_val) % $signed(den);
    assign uquot = rs_val / den;
    assign urem  = rs_val % den;

    always_comb begin
        result = '0;
        case (mdu_op_e'(op))
            MDU_MULT:  result = sprod;
            MDU_MULTU: result = uprod;
            MDU_DIV: begin
                if (den_zero)      result = {rs_val, 32'hFFFF_FFFF};
                else if (sdiv_ovf) result = {32'h0000_0000, 32'h8000_0000};
                else               result = {srem, squot};
            end
            MDU_DIVU: begin
                if (den_zero) result = {rs_val, 32'hFFFF_FFFF};
                else          result = {urem, uquot};
            end
            default:   result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_unit.sv
// ============================================================================
// Module : mdu_unit
// Brief  : Fixed-latency multiply/divide unit with HI/LO registers and stall handshake
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [MDU_W-1:0] rs_val,
    input  logic [MDU_W-1:0] rt_val,
    input  logic             e_valid,
    output logic [MDU_W-1:0] mdu_out,
    output logic             busy,
    output logic             stall_req
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [MDU_W-1:0]   hi_reg;
    logic [MDU_W-1:0]   lo_reg;
    logic [MDU_W-1:0]   pend_hi;
    logic [MDU_W-1:0]   pend_lo;
    logic [CNT_W-1:0]   cnt;
    logic [2*MDU_W-1:0] calc_result;
    logic               md_op;
    logic               accept;
    logic               is_mul;

    mdu_calc u_calc (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .result (calc_result)
    );

    assign md_op     = is_md_op(op);
    assign accept    = e_valid && md_op && !busy;
    assign is_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
    assign stall_req = busy || (e_valid && md_op);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg  <= '0;
            lo_reg  <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (busy) begin
            // Every request arriving while busy is dropped; the hazard unit holds D.
            if (cnt == CNT_W'(1)) begin
                hi_reg <= pend_hi;
                lo_reg <= pend_lo;
                busy   <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (accept) begin
            pend_hi <= calc_result[2*MDU_W-1:MDU_W];
            pend_lo <= calc_result[MDU_W-1:0];
            cnt     <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            busy    <= 1'b1;
        end else if (e_valid && (op == MDU_MTHI)) begin
            hi_reg <= rs_val;
        end else if (e_valid && (op == MDU_MTLO)) begin
            lo_reg <= rs_val;
        end
    end

    always_comb begin
        mdu_out = '0;
        if (op == MDU_MFHI)      mdu_out = hi_reg;
        else if (op == MDU_MFLO) mdu_out = lo_reg;
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// ============================================================================
// Module : tb_mdu_unit
// Brief  : Directed self-checking bench for mdu_unit
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        e_valid;
    logic [31:0] mdu_out;
    logic        busy;
    logic        stall_req;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    mdu_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .e_valid   (e_valid),
        .mdu_out   (mdu_out),
        .busy      (busy),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag);
        op = MDU_MFHI;
        #1 check({tag, "_hi"}, mdu_out, m_hi);
        op = MDU_MFLO;
        #1 check({tag, "_lo"}, mdu_out, m_lo);
    endtask

    // Issue an md op, then hold MFHI (valid or bubble) through the busy window.
    task automatic md_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic hold_valid);
        op = o; rs_val = a; rt_val = b; e_valid = 1'b1;
        #1 check({tag, "_stall_issue"}, {31'd0, stall_req}, 32'd1);
        step();
        op = MDU_MFHI; e_valid = hold_valid;
        for (int i = 0; i < lat; i++) begin
            #1;
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_stall"}, {31'd0, stall_req}, 32'd1);
            check({tag, "_hi_held"}, mdu_out, m_hi);
            step();
        end
        e_valid = 1'b0;
        #1 check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        m_hi = ehi; m_lo = elo;
        check_hilo(tag);
    endtask

    initial begin
        reset = 1'b0; op = MDU_NONE; rs_val = '0; rt_val = '0; e_valid = 1'b0;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check_hilo("rst");
        reset = 1'b1;
        step();

        md_op("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        md_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        md_op("mult_m1sq", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001, 1'b0);
        md_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        md_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        md_op("divu_big", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        md_op("divu_zero", MDU_DIVU, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
        md_op("div_zero", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        md_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);

        // mthi / mtlo take effect at the next edge with no latency
        op = MDU_MTHI; rs_val = 32'h1234_5678; e_valid = 1'b1;
        step();
        #1 check("mthi_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'h1234_5678;
        check_hilo("mthi");
        op = MDU_MTLO; rs_val = 32'hAABB_CCDD;
        step();
        m_lo = 32'hAABB_CCDD;
        check_hilo("mtlo");
        e_valid = 1'b0;

        // mfhi held valid while busy keeps stall asserted; div follows right after busy falls
        md_op("mult_mfhi", MDU_MULT, 32'd6, 32'd7, 5, 32'h0000_0000, 32'h0000_002A, 1'b1);
        md_op("b2b_div", MDU_DIV, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E, 1'b0);

        // Bubble slots: op ignored when e_valid is low
        op = MDU_MULT; rs_val = 32'd9; rt_val = 32'd9; e_valid = 1'b0;
        #1 check("bubble_stall", {31'd0, stall_req}, 32'd0);
        step();
        check("bubble_busy", {31'd0, busy}, 32'd0);
        op = MDU_MTHI;
        step();
        check_hilo("bubble");

        // Mid-operation reset aborts and discards the pending result
        op = MDU_DIV; rs_val = 32'd50; rt_val = 32'd3; e_valid = 1'b1;
        step();
        e_valid = 1'b0; op = MDU_NONE;
        step();
        step();
        step();
        reset = 1'b0;
        #1 check("abort_busy", {31'd0, busy}, 32'd0);
        m_hi = '0; m_lo = '0;
        check_hilo("abort");
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check_hilo("abort_late");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
